// File: rtl/alu_result_stage_pkg.sv
// ============================================================================
// alu_result_stage_pkg : shared widths, EX/MEM entry type and skid states
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_result_stage_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int FUNCT3_W   = 3;

  typedef struct packed {
    logic [XLEN-1:0]       alu_out;
    logic [XLEN-1:0]       store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_we;
    logic                  mem_we;
    logic                  mem_re;
    logic [FUNCT3_W-1:0]   funct3;
  } ex_mem_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_result_stage_if.sv
// ============================================================================
// alu_result_stage_if : execute-to-memory handshake bundle with entry fields
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_result_stage_if;
  import alu_result_stage_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       in_alu_out;
  logic [XLEN-1:0]       in_store_data;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_reg_we;
  logic                  in_mem_we;
  logic                  in_mem_re;
  logic [FUNCT3_W-1:0]   in_funct3;
  logic                  flush;

  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_alu_out;
  logic [XLEN-1:0]       out_store_data;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_reg_we;
  logic                  out_mem_we;
  logic                  out_mem_re;
  logic [FUNCT3_W-1:0]   out_funct3;

  // Stage side: consumes the in_* fields, drives the out_* fields
  modport slave (
    input  in_valid, in_alu_out, in_store_data, in_rd, in_reg_we,
           in_mem_we, in_mem_re, in_funct3, flush, out_ready,
    output in_ready, out_valid, out_alu_out, out_store_data, out_rd,
           out_reg_we, out_mem_we, out_mem_re, out_funct3
  );

  modport master (
    output in_valid, in_alu_out, in_store_data, in_rd, in_reg_we,
           in_mem_we, in_mem_re, in_funct3, flush, out_ready,
    input  in_ready, out_valid, out_alu_out, out_store_data, out_rd,
           out_reg_we, out_mem_we, out_mem_re, out_funct3
  );

endinterface

`default_nettype wire

// File: rtl/alu_result_stage_skid_buffer.sv
// ============================================================================
// skid_buffer : two-entry (main + skid) register slice with registered ready
// Rev 1.0
// ============================================================================
`default_nettype none

module skid_buffer
  import alu_result_stage_pkg::*;
#(
  parameter type T = ex_mem_t
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic flush,
  input  wire logic in_valid,
  output logic      in_ready,
  input  wire T     in_data,
  output logic      out_valid,
  input  wire logic out_ready,
  output T          out_data
);

  skid_state_t r_state;
  skid_state_t w_next;
  T            r_main;
  T            r_skid;
  logic        r_in_ready;
  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_load_main;
  logic        w_load_skid;
  logic        w_skid_to_main;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_next         = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: if (w_in_xfer) begin
          w_next      = S_ONE;
          w_load_main = 1'b1;
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_main = 1'b1;
          end else if (w_in_xfer) begin
            w_next      = S_FULL;
            w_load_skid = 1'b1;
          end else if (w_out_xfer) begin
            w_next = S_EMPTY;
          end
        end
        S_FULL: if (w_out_xfer) begin
          w_next         = S_ONE;
          w_skid_to_main = 1'b1;
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // Ready is derived from the next state so it never depends on out_ready combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_FULL);
      if (w_load_main)         r_main <= in_data;
      else if (w_skid_to_main) r_main <= r_skid;
      if (w_load_skid)         r_skid <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != S_EMPTY);
  assign out_data  = r_main;

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ============================================================================
// alu_result_stage : EX/MEM register slice with x0 write suppression
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_result_stage
  import alu_result_stage_pkg::*;
(
  input wire logic          clk,
  input wire logic          rst_n,
  alu_result_stage_if.slave bus
);

  ex_mem_t w_in_entry;
  ex_mem_t w_out_entry;
  logic    w_out_valid;
  logic    w_in_ready;

  // Writes to x0 are dropped at capture so downstream never sees them
  always_comb begin
    w_in_entry            = '0;
    w_in_entry.alu_out    = bus.in_alu_out;
    w_in_entry.store_data = bus.in_store_data;
    w_in_entry.rd         = bus.in_rd;
    w_in_entry.reg_we     = bus.in_reg_we && (bus.in_rd != '0);
    w_in_entry.mem_we     = bus.in_mem_we;
    w_in_entry.mem_re     = bus.in_mem_re;
    w_in_entry.funct3     = bus.in_funct3;
  end

  skid_buffer #(
    .T (ex_mem_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_in_entry),
    .out_valid (w_out_valid),
    .out_ready (bus.out_ready),
    .out_data  (w_out_entry)
  );

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_alu_out    = w_out_entry.alu_out;
  assign bus.out_store_data = w_out_entry.store_data;
  assign bus.out_rd         = w_out_entry.rd;
  assign bus.out_funct3     = w_out_entry.funct3;
  assign bus.out_reg_we     = w_out_valid && w_out_entry.reg_we;
  assign bus.out_mem_we     = w_out_valid && w_out_entry.mem_we;
  assign bus.out_mem_re     = w_out_valid && w_out_entry.mem_re;

endmodule

`default_nettype wire
